// File: rtl/mem_net_injector_pkg.sv
// Shared types for the memory network injector: flit layout, FSM states and core config.
package mem_net_injector_pkg;

    localparam int BEATS = 4;

    typedef struct packed {
        logic [3:0] mode;
        logic       bypass;
        logic [2:0] lane_mask;
    } morph_config_t;

    typedef struct packed {
        logic        last;
        logic        is_read;
        logic        is_wide;
        logic [1:0]  src_core;
        logic [1:0]  beat;
        logic [31:0] addr;
        logic [63:0] data;
    } net_flit_t;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_RESP,
        RESP
    } state_t;

endpackage

// File: rtl/flit_reassembler.sv
// Captures read-response beats into the wide buffer, counts own beats and runs the response watchdog.
module flit_reassembler
    import mem_net_injector_pkg::*;
#(
    parameter logic [1:0] CORE_ID        = 2'd0,
    parameter int         WIDE_WIDTH     = 256,
    parameter int         FLIT_DATA_W    = 64,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  active,
    input  logic                  is_wide,
    input  net_flit_t             net_flit_in,
    input  logic                  net_req_in,
    output logic                  net_ack_out,
    output logic [WIDE_WIDTH-1:0] buf_data,
    output logic                  done,
    output logic                  expired
);
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int CNT_W = $clog2(BEATS) + 1;

    logic [CNT_W-1:0] cnt_p0;
    logic [WD_W-1:0]  wd_p0;
    logic             take_own;
    logic [1:0]       slot;
    logic [CNT_W-1:0] expected;
    logic             unused_flit_bits;

    assign net_ack_out = active && net_req_in;
    assign take_own    = net_ack_out && (net_flit_in.src_core == CORE_ID);
    assign slot        = is_wide ? net_flit_in.beat : 2'd0;
    assign expected    = is_wide ? CNT_W'(BEATS) : CNT_W'(1);
    assign done        = take_own && ((cnt_p0 + CNT_W'(1)) == expected);
    assign expired     = active && (wd_p0 == WD_W'(TIMEOUT_CYCLES - 1));

    assign unused_flit_bits = ^{net_flit_in.last, net_flit_in.is_read, net_flit_in.is_wide,
                                net_flit_in.addr, net_flit_in.data};

    // Stage p0: buffer, beat count and watchdog all restart when a read enters WAIT_RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_p0   <= '0;
            wd_p0    <= '0;
            buf_data <= '0;
        end else if (clear) begin
            cnt_p0   <= '0;
            wd_p0    <= '0;
            buf_data <= '0;
        end else if (active) begin
            wd_p0 <= wd_p0 + WD_W'(1);
            if (take_own) begin
                cnt_p0 <= cnt_p0 + CNT_W'(1);
                buf_data[slot*FLIT_DATA_W +: FLIT_DATA_W] <= net_flit_in.data[FLIT_DATA_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_net_injector.sv
// Core-side injector: packetizes one request into flits, then reassembles the read response.
module mem_net_injector
    import mem_net_injector_pkg::*;
#(
    parameter logic [1:0] CORE_ID        = 2'd0,
    parameter int         WIDE_WIDTH     = 256,
    parameter int         FLIT_DATA_W    = 64,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_read,
    input  logic                  req_is_wide,
    input  logic [31:0]           req_addr,
    input  logic [WIDE_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [WIDE_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output net_flit_t             net_flit_out,
    output logic                  net_req_out,
    input  logic                  net_ack_in,
    input  net_flit_t             net_flit_in,
    input  logic                  net_req_in,
    output logic                  net_ack_out
);
    state_t                state_p0, state_nxt;
    logic                  rd_p0, wide_p0;
    logic [31:0]           addr_p0;
    logic [WIDE_WIDTH-1:0] wdata_p0;
    logic [1:0]            beat_p0;
    logic                  err_p0;
    logic                  accept, last_beat, beat_xfer, send_done;
    logic                  reasm_done, reasm_expired;

    assign req_ready   = (state_p0 == IDLE);
    assign net_req_out = (state_p0 == SEND);
    assign resp_valid  = (state_p0 == RESP);
    assign resp_err    = resp_valid && err_p0;
    assign accept      = req_valid && req_ready;
    assign last_beat   = (rd_p0 || !wide_p0) ? 1'b1 : (beat_p0 == 2'(BEATS - 1));
    assign beat_xfer   = net_req_out && net_ack_in;
    assign send_done   = beat_xfer && last_beat;

    // Flit is a pure function of captured request and beat, so it stays stable under stall
    always_comb begin
        net_flit_out = '0;
        if (state_p0 == SEND) begin
            net_flit_out.last     = last_beat;
            net_flit_out.is_read  = rd_p0;
            net_flit_out.is_wide  = wide_p0;
            net_flit_out.src_core = CORE_ID;
            net_flit_out.beat     = beat_p0;
            net_flit_out.addr     = addr_p0;
            if (!rd_p0)
                net_flit_out.data = 64'(wdata_p0[beat_p0*FLIT_DATA_W +: FLIT_DATA_W]);
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:      if (accept) state_nxt = SEND;
            SEND:      if (send_done) state_nxt = rd_p0 ? WAIT_RESP : IDLE;
            WAIT_RESP: if (reasm_done || reasm_expired) state_nxt = RESP;
            RESP:      if (resp_ready) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Stage p0: control state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
            beat_p0  <= '0;
            err_p0   <= 1'b0;
        end else begin
            state_p0 <= state_nxt;
            if (accept) begin
                beat_p0 <= '0;
                err_p0  <= 1'b0;
            end else if (beat_xfer && !last_beat) begin
                beat_p0 <= beat_p0 + 2'd1;
            end
            if (state_p0 == WAIT_RESP && state_nxt == RESP)
                err_p0 <= !reasm_done;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rd_p0    <= req_is_read;
            wide_p0  <= req_is_wide;
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    flit_reassembler #(
        .CORE_ID        (CORE_ID),
        .WIDE_WIDTH     (WIDE_WIDTH),
        .FLIT_DATA_W    (FLIT_DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_reasm (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (send_done && rd_p0),
        .active      (state_p0 == WAIT_RESP),
        .is_wide     (wide_p0),
        .net_flit_in (net_flit_in),
        .net_req_in  (net_req_in),
        .net_ack_out (net_ack_out),
        .buf_data    (resp_data),
        .done        (reasm_done),
        .expired     (reasm_expired)
    );

endmodule

// File: tb/tb_mem_net_injector.sv
// Directed bench for mem_net_injector: write vector table plus read, timeout, foreign-flit and reset sequences.
module tb_mem_net_injector;
    import mem_net_injector_pkg::*;

    localparam int         WW  = 256;
    localparam int         TO  = 8;
    localparam logic [1:0] CID = 2'd1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            req_valid = 1'b0, req_is_read = 1'b0, req_is_wide = 1'b0;
    logic            req_ready;
    logic [31:0]     req_addr = '0;
    logic [WW-1:0]   req_wdata = '0;
    logic            resp_valid, resp_err;
    logic            resp_ready = 1'b0;
    logic [WW-1:0]   resp_data;
    net_flit_t       net_flit_out;
    logic            net_req_out;
    logic            net_ack_in = 1'b0;
    net_flit_t       net_flit_in = '0;
    logic            net_req_in = 1'b0;
    logic            net_ack_out;

    mem_net_injector #(
        .CORE_ID        (CID),
        .WIDE_WIDTH     (WW),
        .FLIT_DATA_W    (64),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_is_read  (req_is_read),
        .req_is_wide  (req_is_wide),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_data    (resp_data),
        .resp_err     (resp_err),
        .net_flit_out (net_flit_out),
        .net_req_out  (net_req_out),
        .net_ack_in   (net_ack_in),
        .net_flit_in  (net_flit_in),
        .net_req_in   (net_req_in),
        .net_ack_out  (net_ack_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic            is_wide;
        logic [31:0]     addr;
        logic [WW-1:0]   wdata;
        int              stall;
        int              nflits;
        logic [3:0][63:0] exp_data;
    } wr_vec_t;

    wr_vec_t   wv [4];
    net_flit_t got_flits [8];
    int        got_n;
    int        send_cycles;
    int        errors = 0;
    int        checks = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // All sequence tasks start and end 2 time units after a rising edge.
    task automatic issue(input logic rd, input logic wide, input logic [31:0] a, input logic [WW-1:0] d);
        req_valid = 1'b1; req_is_read = rd; req_is_wide = wide; req_addr = a; req_wdata = d;
        #0;
        chk("ready_before_accept", 256'(req_ready), 256'(1'b1));
        step();
        req_valid = 1'b0;
        #1;
        chk("ready_low_after_accept", 256'(req_ready), 256'(1'b0));
    endtask

    task automatic collect(input int stall);
        net_flit_t snap;
        int guard;
        guard = 0; got_n = 0; send_cycles = 0;
        while (net_req_out && guard < 100) begin
            snap = net_flit_out;
            for (int s = 0; s < stall; s++) begin
                step(); #1; send_cycles++;
                chk("flit_stable", 256'(net_flit_out), 256'(snap));
            end
            net_ack_in = 1'b1;
            if (got_n < 8) got_flits[got_n] = net_flit_out;
            got_n++;
            step(); send_cycles++;
            net_ack_in = 1'b0;
            #1;
            guard++;
        end
        if (guard >= 100) begin
            checks++; errors++;
            $display("FAIL send_guard: net_req_out still high after %0d beats, required drop", guard);
        end
    endtask

    task automatic resp_flit(input logic [1:0] src, input logic [1:0] beat, input logic [63:0] d);
        net_flit_in = '0;
        net_flit_in.is_read = 1'b1; net_flit_in.src_core = src;
        net_flit_in.beat = beat; net_flit_in.data = d;
        net_req_in = 1'b1;
        #1;
        chk("ack_out_in_wait", 256'(net_ack_out), 256'(1'b1));
        step();
        net_req_in = 1'b0;
        #1;
    endtask

    task automatic finish_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        #1;
        chk("resp_valid_drop", 256'(resp_valid), 256'(1'b0));
        chk("ready_after_resp", 256'(req_ready), 256'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [WW-1:0] snap_data;
        int n;

        wv[0] = '{is_wide: 1'b0, addr: 32'h100, wdata: 256'hDEADBEEF, stall: 0, nflits: 1,
                  exp_data: {64'h0, 64'h0, 64'h0, 64'hDEADBEEF}};
        wv[1] = '{is_wide: 1'b1, addr: 32'h200, wdata: {64'h44, 64'h33, 64'h22, 64'h11}, stall: 3, nflits: 4,
                  exp_data: {64'h44, 64'h33, 64'h22, 64'h11}};
        wv[2] = '{is_wide: 1'b0, addr: 32'h3FC,
                  wdata: {64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB, 64'hCCCC_CCCC_CCCC_CCCC, 64'h0123_4567_89AB_CDEF},
                  stall: 1, nflits: 1,
                  exp_data: {64'h0, 64'h0, 64'h0, 64'h0123_4567_89AB_CDEF}};
        wv[3] = '{is_wide: 1'b1, addr: 32'h4000,
                  wdata: {64'hF0F0_F0F0_F0F0_F0F0, 64'h8000_0000_0000_0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF},
                  stall: 0, nflits: 4,
                  exp_data: {64'hF0F0_F0F0_F0F0_F0F0, 64'h8000_0000_0000_0001, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF}};

        // Reset state
        net_req_in = 1'b1;
        @(posedge clk); #2;
        chk("rst_req_ready",   256'(req_ready),    256'(1'b1));
        chk("rst_resp_valid",  256'(resp_valid),   256'(1'b0));
        chk("rst_resp_err",    256'(resp_err),     256'(1'b0));
        chk("rst_net_req_out", 256'(net_req_out),  256'(1'b0));
        chk("rst_net_ack_out", 256'(net_ack_out),  256'(1'b0));
        chk("rst_resp_data",   resp_data,          256'(0));
        chk("rst_flit_out",    256'(net_flit_out), 256'(0));
        net_req_in = 1'b0;
        rst_n = 1'b1;

        // Write vector table
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, wv[i].is_wide, wv[i].addr, wv[i].wdata);
            collect(wv[i].stall);
            chk("wr_flit_count", 256'(got_n), 256'(wv[i].nflits));
            chk("wr_send_cycles", 256'(send_cycles), 256'(wv[i].nflits * (wv[i].stall + 1)));
            chk("wr_ready_back", 256'(req_ready), 256'(1'b1));
            for (int b = 0; b < got_n && b < 8; b++) begin
                chk("wr_data",     256'(got_flits[b].data),     256'(wv[i].exp_data[b]));
                chk("wr_beat",     256'(got_flits[b].beat),     256'(b));
                chk("wr_last",     256'(got_flits[b].last),     256'(b == wv[i].nflits - 1));
                chk("wr_src_core", 256'(got_flits[b].src_core), 256'(CID));
                chk("wr_is_read",  256'(got_flits[b].is_read),  256'(1'b0));
                chk("wr_is_wide",  256'(got_flits[b].is_wide),  256'(wv[i].is_wide));
                chk("wr_addr",     256'(got_flits[b].addr),     256'(wv[i].addr));
            end
        end

        // Wide read, response beats out of order, response held under backpressure
        issue(1'b1, 1'b1, 32'h2000, '1);
        collect(0);
        chk("rd_flit_count", 256'(got_n), 256'(1));
        chk("rd_flit_isread", 256'(got_flits[0].is_read), 256'(1'b1));
        chk("rd_flit_data", 256'(got_flits[0].data), 256'(0));
        chk("rd_flit_last", 256'(got_flits[0].last), 256'(1'b1));
        resp_flit(CID, 2'd2, 64'hB2B2_0000_0000_0002);
        resp_flit(CID, 2'd0, 64'hB0B0_0000_0000_0000);
        resp_flit(CID, 2'd3, 64'hB3B3_0000_0000_0003);
        chk("rd_not_done_early", 256'(resp_valid), 256'(1'b0));
        resp_flit(CID, 2'd1, 64'hB1B1_0000_0000_0001);
        chk("rd_resp_valid", 256'(resp_valid), 256'(1'b1));
        chk("rd_resp_err", 256'(resp_err), 256'(1'b0));
        chk("rd_resp_data", resp_data,
            {64'hB3B3_0000_0000_0003, 64'hB2B2_0000_0000_0002, 64'hB1B1_0000_0000_0001, 64'hB0B0_0000_0000_0000});
        snap_data = resp_data;
        for (int c = 0; c < 5; c++) begin
            step(); #1;
            chk("rd_hold_valid", 256'(resp_valid), 256'(1'b1));
            chk("rd_hold_data", resp_data, snap_data);
        end
        finish_resp();

        // Watchdog expiry with two of four beats, missing slots must read zero
        issue(1'b1, 1'b1, 32'h2100, '0);
        collect(0);
        resp_flit(CID, 2'd0, 64'h5555);
        resp_flit(CID, 2'd3, 64'h7777);
        n = 0;
        while (!resp_valid && n < 50) begin
            step(); #1; n++;
        end
        chk("to_wait_cycles", 256'(n), 256'(6));
        chk("to_resp_err", 256'(resp_err), 256'(1'b1));
        chk("to_resp_data", resp_data, {64'h7777, 64'h0, 64'h0, 64'h5555});
        net_req_in = 1'b1;
        #1;
        chk("ack_zero_in_resp", 256'(net_ack_out), 256'(1'b0));
        net_req_in = 1'b0;
        finish_resp();

        // Final beat lands in the same cycle the watchdog expires
        issue(1'b1, 1'b0, 32'h2200, '0);
        collect(0);
        for (int c = 0; c < TO - 1; c++) step();
        resp_flit(CID, 2'd0, 64'hFACE);
        chk("race_resp_valid", 256'(resp_valid), 256'(1'b1));
        chk("race_resp_err", 256'(resp_err), 256'(1'b0));
        chk("race_resp_data", resp_data, 256'(64'hFACE));
        finish_resp();

        // Foreign flit is acked and dropped; narrow response lands in slot 0 whatever its beat
        issue(1'b1, 1'b0, 32'h3000, '0);
        collect(0);
        resp_flit(2'd2, 2'd0, 64'hBAD0_BAD0);
        chk("foreign_not_done", 256'(resp_valid), 256'(1'b0));
        resp_flit(CID, 2'd2, 64'hC0FFEE);
        chk("own_resp_valid", 256'(resp_valid), 256'(1'b1));
        chk("own_resp_err", 256'(resp_err), 256'(1'b0));
        chk("own_resp_data", resp_data, 256'(64'hC0FFEE));
        finish_resp();

        // Reset during beat 2 of a wide write
        issue(1'b0, 1'b1, 32'h5000, {64'hD3, 64'hD2, 64'hD1, 64'hD0});
        for (int b = 0; b < 2; b++) begin
            net_ack_in = 1'b1;
            step();
            net_ack_in = 1'b0;
            #1;
        end
        chk("pre_rst_beat", 256'(net_flit_out.beat), 256'(2));
        chk("pre_rst_req", 256'(net_req_out), 256'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("rst_mid_req_out", 256'(net_req_out), 256'(1'b0));
        chk("rst_mid_ready", 256'(req_ready), 256'(1'b1));
        chk("rst_mid_flit", 256'(net_flit_out), 256'(0));
        step();
        rst_n = 1'b1;
        #1;
        issue(1'b0, 1'b1, 32'h6000, {64'hE3, 64'hE2, 64'hE1, 64'hE0});
        collect(0);
        chk("post_rst_count", 256'(got_n), 256'(4));
        chk("post_rst_beat0", 256'(got_flits[0].beat), 256'(0));
        chk("post_rst_data0", 256'(got_flits[0].data), 256'(64'hE0));
        chk("post_rst_last3", 256'(got_flits[3].last), 256'(1'b1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
